// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer controllers:
// write-side FSM states, Gray/binary conversion and default geometry.
package fifo_pkg;

    localparam int PTR_WIDTH_DEF   = 4;
    localparam int DEPTH_WIDTH_DEF = 16;
    localparam int GRAY_MAX_W      = 32;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } wr_state_e;

    // Both conversions work on a zero-extended value, so any pointer up to
    // GRAY_MAX_W bits converts correctly in its low bits.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1'b1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded FIFO pointer crossing into the
// local clock domain; both stages reset asynchronously to zero.
module fifo_ptr_sync #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] ptr_gray_i,
    output logic [WIDTH-1:0] ptr_gray_sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= ptr_gray_i;
            sync_q <= meta_q;
        end
    end

    assign ptr_gray_sync_o = sync_q;

endmodule

// File: rtl/fifo_write.sv
// Write-domain pointer and flag controller of the asynchronous FIFO.
// Define FIFO_WR_ALMOST_FULL_EN to build the almost_full register and compare.
module fifo_write
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int PTR_WIDTH          = PTR_WIDTH_DEF,
    parameter int DEPTH_WIDTH        = DEPTH_WIDTH_DEF,
    parameter int ALMOST_FULL_THRESH = DEPTH_WIDTH - 2
) (
    input  logic               w_clk,
    input  logic               wreset,
    input  logic               flush,
    input  logic               wr_enable,
    input  logic [PTR_WIDTH:0] read_ptr_gray,
    output logic               fifo_wr_enable,
    output logic               full,
    output logic               almost_full,
    output logic               overflow,
    output logic [PTR_WIDTH:0] wr_level,
    output logic [PTR_WIDTH:0] write_ptr,
    output logic [PTR_WIDTH:0] write_ptr_gray
);

    localparam int PW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] DEPTH_LVL = PW'(DEPTH_WIDTH);
    localparam logic [PTR_WIDTH:0] PTR_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};

    wr_state_e          state_q, state_d;
    logic               init_cnt_q, init_cnt_d;
    logic [PTR_WIDTH:0] wptr_q, wptr_d;
    logic [PTR_WIDTH:0] wgray_q, wgray_d;
    logic [PTR_WIDTH:0] level_q, level_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic               accept_s;
    logic [PTR_WIDTH:0] rsync_gray_s;
    logic [PTR_WIDTH:0] rptr_bin_s;

    fifo_ptr_sync #(
        .WIDTH (PW)
    ) u_rptr_sync (
        .clk_i           (w_clk),
        .rst_i           (wreset),
        .ptr_gray_i      (read_ptr_gray),
        .ptr_gray_sync_o (rsync_gray_s)
    );

    assign rptr_bin_s = PW'(gray2bin(GRAY_MAX_W'(rsync_gray_s)));

    // FSM next state, pointer advance, overflow tracking and next flags.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = 1'b0;
        wptr_d     = wptr_q;
        ovf_d      = ovf_q;
        accept_s   = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = 1'b1;
                if (init_cnt_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    wptr_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_FLUSH;
                end else begin
                    accept_s = wr_enable & ~full_q;
                    if (accept_s) begin
                        wptr_d = wptr_q + PTR_ONE;
                    end else begin
                        wptr_d = wptr_q;
                    end
                    if (wr_enable & full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                end
            end
            ST_FLUSH: begin
                // Leave only once the read side is seen back at zero.
                if (!flush && (rsync_gray_s == '0)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        level_d = wptr_d - rptr_bin_s;
        wgray_d = PW'(bin2gray(GRAY_MAX_W'(wptr_d)));
        if (state_d != ST_RUN) begin
            full_d = 1'b1;
        end else begin
            full_d = (level_d == DEPTH_LVL);
        end
    end

    // State, pointer and flag registers.
    always_ff @(posedge w_clk or posedge wreset) begin
        if (wreset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 1'b0;
            wptr_q     <= '0;
            wgray_q    <= '0;
            level_q    <= '0;
            full_q     <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wptr_q     <= wptr_d;
            wgray_q    <= wgray_d;
            level_q    <= level_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef FIFO_WR_ALMOST_FULL_EN
    localparam logic [PTR_WIDTH:0] AF_LVL = PW'(ALMOST_FULL_THRESH);
    logic af_q, af_d;

    // Threshold compare on the same next level that feeds wr_level.
    always_comb begin
        af_d = (level_d >= AF_LVL);
    end

    // Almost-full register.
    always_ff @(posedge w_clk or posedge wreset) begin
        if (wreset) begin
            af_q <= 1'b0;
        end else begin
            af_q <= af_d;
        end
    end

    assign almost_full = af_q;
`else
    assign almost_full = 1'b0;
`endif

    assign fifo_wr_enable = accept_s;
    assign full           = full_q;
    assign overflow       = ovf_q;
    assign wr_level       = level_q;
    assign write_ptr      = wptr_q;
    assign write_ptr_gray = wgray_q;

endmodule

// File: tb/tb_fifo_write.sv
// Self-checking bench for fifo_write: directed scenarios plus randomized
// traffic, compared against a behavioural model of the write-side rules.
module tb_fifo_write;

`ifdef FIFO_WR_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic       w_clk = 1'b0;
    logic       wreset;
    logic       flush;
    logic       wr_enable;
    logic [4:0] read_ptr_gray;
    logic       fifo_wr_enable;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic [4:0] wr_level;
    logic [4:0] write_ptr;
    logic [4:0] write_ptr_gray;

    fifo_write #(
        .DATA_WIDTH         (8),
        .PTR_WIDTH          (4),
        .DEPTH_WIDTH        (16),
        .ALMOST_FULL_THRESH (14)
    ) dut (
        .w_clk          (w_clk),
        .wreset         (wreset),
        .flush          (flush),
        .wr_enable      (wr_enable),
        .read_ptr_gray  (read_ptr_gray),
        .fifo_wr_enable (fifo_wr_enable),
        .full           (full),
        .almost_full    (almost_full),
        .overflow       (overflow),
        .wr_level       (wr_level),
        .write_ptr      (write_ptr),
        .write_ptr_gray (write_ptr_gray)
    );

    always #5 w_clk = ~w_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 = init, 1 = run, 2 = flush.
    int m_mode, m_init_cnt, m_wptr, m_level;
    bit m_full, m_af, m_ovf;
    int rp1, rp2;
    int rd_b;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    function automatic int g2b(input int g);
        for (int b = 0; b < 32; b++) begin
            if (b2g(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_init_cnt = 0; m_wptr = 0; m_level = 0;
        m_full = 1'b1; m_af = 1'b0; m_ovf = 1'b0;
        rp1 = 0; rp2 = 0;
    endtask

    task automatic check_outputs(input string pfx, input bit exp_acc);
        check_eq({pfx, "_wr_en"}, fifo_wr_enable, exp_acc);
        check_eq({pfx, "_full"}, full, m_full);
        check_eq({pfx, "_afull"}, almost_full, m_af);
        check_eq({pfx, "_ovf"}, overflow, m_ovf);
        check_eq({pfx, "_level"}, wr_level, m_level);
        check_eq({pfx, "_wptr"}, write_ptr, m_wptr);
        check_eq({pfx, "_wgray"}, write_ptr_gray, b2g(m_wptr));
    endtask

    // Drive one cycle of inputs, check, advance the model by one edge.
    task automatic step(input bit we, input bit fl);
        bit acc;
        int rb;
        wr_enable     = we;
        flush         = fl;
        read_ptr_gray = 5'(b2g(rd_b));
        #1;
        acc = (m_mode == 1) && we && !m_full && !fl;
        check_outputs("cyc", acc);
        rb = g2b(rp2);
        if (m_mode == 0) begin
            m_init_cnt++;
            if (m_init_cnt == 2) m_mode = 1;
        end else if (m_mode == 1) begin
            if (fl) begin
                m_wptr = 0; m_ovf = 1'b0; m_mode = 2;
            end else begin
                if (acc) m_wptr = (m_wptr + 1) % 32;
                if (we && m_full) m_ovf = 1'b1;
            end
        end else begin
            if (!fl && rb == 0) m_mode = 1;
        end
        m_level = (m_wptr - rb + 32) % 32;
        m_full  = (m_mode != 1) || (m_level == 16);
        m_af    = AF_EN && (m_level >= 14);
        rp2 = rp1;
        rp1 = b2g(rd_b);
        @(posedge w_clk);
        @(negedge w_clk);
    endtask

    initial begin
        wreset = 1'b1; flush = 1'b0; wr_enable = 1'b0; read_ptr_gray = 5'd0;
        rd_b = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge w_clk);
            check_eq("rst_full", full, 1'b1);
            check_eq("rst_wptr", write_ptr, 5'd0);
            check_eq("rst_level", wr_level, 5'd0);
            check_eq("rst_ovf", overflow, 1'b0);
        end
        wreset = 1'b0;

        // Init window: full for two edges, then clear.
        step(1'b0, 1'b0);
        check_eq("init_full_e1", full, 1'b1);
        step(1'b0, 1'b0);
        check_eq("init_full_e2", full, 1'b0);

        // Fill sixteen, then one refused write.
        repeat (16) step(1'b1, 1'b0);
        check_eq("fill_wptr", write_ptr, 5'b10000);
        check_eq("fill_wgray", write_ptr_gray, 5'b11000);
        check_eq("fill_full", full, 1'b1);
        check_eq("fill_level", wr_level, 5'd16);
        step(1'b1, 1'b0);
        check_eq("fill_ovf", overflow, 1'b1);

        // Drain visibility: three edges of latency.
        rd_b = 1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("drain_full_e2", full, 1'b1);
        step(1'b0, 1'b0);
        check_eq("drain_full_e3", full, 1'b0);
        check_eq("drain_level_e3", wr_level, 5'd15);

        // Wrap the write pointer from 31 to 0 with the reader at 16.
        for (int i = 2; i <= 16; i++) begin
            rd_b = i;
            step(1'b0, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b0);
        check_eq("wrap_wptr31", write_ptr, 5'd31);
        step(1'b1, 1'b0);
        check_eq("wrap_wptr0", write_ptr, 5'd0);
        check_eq("wrap_level", wr_level, 5'd16);
        check_eq("wrap_full", full, 1'b1);

        // Flush colliding with a write at write_ptr 7.
        for (int i = 0; i < 16; i++) begin
            rd_b = (rd_b + 1) % 32;
            step(1'b0, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0);
        repeat (7) step(1'b1, 1'b0);
        check_eq("flush_pre_wptr", write_ptr, 5'd7);
        step(1'b1, 1'b1);
        check_eq("flush_wptr", write_ptr, 5'd0);
        check_eq("flush_ovf", overflow, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check_eq("flush_hold_full", full, 1'b1);
        step(1'b0, 1'b0);
        check_eq("flush_exit_full", full, 1'b0);

        // Randomized traffic with occasional flushes.
        begin
            int fl_hold = 0;
            for (int c = 0; c < 800; c++) begin
                bit we, fl;
                we = ($urandom_range(3) != 0);
                if (fl_hold > 0) begin
                    fl = 1'b1;
                    fl_hold--;
                end else if ($urandom_range(59) == 0) begin
                    fl = 1'b1;
                    fl_hold = $urandom_range(2);
                    rd_b = 0;
                end else begin
                    fl = 1'b0;
                end
                if (!fl && rd_b != m_wptr && $urandom_range(1) == 0) begin
                    rd_b = (rd_b + 1) % 32;
                end
                step(we, fl);
            end
        end

        // Asynchronous reset in the middle of a cycle.
        @(posedge w_clk);
        #2;
        wreset = 1'b1;
        #1;
        check_eq("arst_full", full, 1'b1);
        check_eq("arst_wptr", write_ptr, 5'd0);
        check_eq("arst_wgray", write_ptr_gray, 5'd0);
        check_eq("arst_level", wr_level, 5'd0);
        check_eq("arst_ovf", overflow, 1'b0);
        check_eq("arst_afull", almost_full, 1'b0);
        @(negedge w_clk);
        wreset = 1'b0;
        rd_b = 0;
        model_reset();
        repeat (24) step(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write.md
# fifo_write

Write-side pointer and flag controller for the asynchronous FIFO, in the write clock domain. It feeds the read-side controller and the dual-port memory. It accepts write requests, advances a binary write pointer and its Gray-coded copy for the domain crossing, and synchronises the read pointer's Gray code into the write domain. From that it derives full, fill level, almost-full and a sticky overflow flag. Flush is coordinated through a small state machine.

## Interface
- DATA_WIDTH, 8, data width, kept for parameter-list uniformity across FIFO blocks; no datapath here
- PTR_WIDTH, 4, memory address width; pointers are PTR_WIDTH+1 bits, the extra MSB being the wrap bit
- DEPTH_WIDTH, 16, FIFO depth; must equal 2**PTR_WIDTH
- ALMOST_FULL_THRESH, DEPTH_WIDTH-2, fill level at or above which almost_full asserts
- w_clk  in  1  write clock, single clock domain for the whole block
- wreset  in  1  reset, asynchronous, active-high
- flush  in  1  clear request, write domain
- wr_enable  in  1  write request
- read_ptr_gray  in  PTR_WIDTH+1  read pointer Gray code, read domain (unsynchronised)
- fifo_wr_enable  out  1  memory write strobe, combinational
- full  out  1  registered full flag
- almost_full  out  1  registered almost-full flag
- overflow  out  1  sticky: a write was attempted while full
- wr_level  out  PTR_WIDTH+1  registered fill level as seen from the write domain
- write_ptr  out  PTR_WIDTH+1  binary write pointer; low PTR_WIDTH bits address memory
- write_ptr_gray  out  PTR_WIDTH+1  registered Gray code of write_ptr, for the read domain

## Operation
- FSM states are ST_INIT, ST_RUN and ST_FLUSH. Reset enters ST_INIT.
- ST_INIT
  - Lasts exactly 2 cycles so the synchroniser fills, then goes to ST_RUN.
  - full=1, fifo_wr_enable=0.
- ST_RUN
  - Accept condition: fifo_wr_enable = wr_enable & ~full & ~flush.
  - On accept, write_ptr increments by 1 modulo 2**(PTR_WIDTH+1).
  - flush=1: next edge sets write_ptr=0 and write_ptr_gray=0, clears overflow, and moves to ST_FLUSH.
- ST_FLUSH
  - full=1, fifo_wr_enable=0.
  - Returns to ST_RUN when flush=0 and the synchronised read Gray pointer equals 0.
- Synchronised read pointer: 2-flop synchroniser, then Gray-to-binary conversion to give rptr_bin.
- Level: next_level = next_wptr - rptr_bin, modulo 2**(PTR_WIDTH+1).
- Registered flags, computed from the next pointer values:
  - wr_level <= next_level
  - full <= (next_level == DEPTH_WIDTH), equivalently MSBs differ and LSBs equal
  - almost_full <= (next_level >= ALMOST_FULL_THRESH)
- overflow is set on wr_enable & full in ST_RUN. It is cleared only by reset or flush.
- Simultaneous events:
  - flush with wr_enable: flush wins, no write.
  - A write and a read-pointer change in the same cycle: both are reflected in next_level.
- Reset values:
  - write_ptr=0, write_ptr_gray=0, wr_level=0
  - full=1, almost_full=0, overflow=0
  - synchroniser flops=0
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Memory contents are not cleared.

## Timing
- Write accept to write_ptr/write_ptr_gray update: same rising edge, both registered.
- full asserts on the edge that accepts the DEPTH_WIDTH-th outstanding write, so a back-to-back write in the next cycle is refused.
- A read-pointer change shows up in full/wr_level 3 w_clk edges later (2 synchroniser edges + 1 flag register). This makes full conservative, never optimistic.
- write_ptr_gray changes at most 1 bit per cycle, which is required for the crossing.
- After wreset deasserts, full=1 for 2 edges, then 0 (given read_ptr_gray=0).

## Configuration
- FIFO_WR_ALMOST_FULL_EN defined: the almost_full register and threshold compare are built; ALMOST_FULL_THRESH is honoured.
- FIFO_WR_ALMOST_FULL_EN undefined: almost_full is tied to 0, no compare logic is built, and the port remains present.

## Structure
- Shared package fifo_pkg holds:
  - the FSM state enum (ST_INIT, ST_RUN, ST_FLUSH)
  - bin2gray and gray2bin functions, parameterised by width
  - the default PTR_WIDTH/DEPTH_WIDTH constants, reused by the read side
- Sub-module fifo_ptr_sync: a 2-flop Gray pointer synchroniser, width PTR_WIDTH+1, async active-high reset to 0. The read side reuses it for write_ptr_gray.

## Test plan
- Reset: hold wreset 3 cycles, then release with read_ptr_gray=0 -> full=1 for 2 edges then 0; write_ptr=0, wr_level=0.
- Fill: 16 back-to-back writes -> write_ptr=5'b10000, write_ptr_gray=5'b11000, full=1 after the 16th, wr_level=16. A 17th request -> fifo_wr_enable=0 and overflow=1.
- Drain visibility: with the FIFO full, drive read_ptr_gray=5'b00001 -> full=0 and wr_level=15 exactly 3 edges later.
- Wrap: read_ptr_gray=gray(16)=5'b11000, write_ptr advanced from 31 to 0 -> wr_level=16 and full=1 on that edge.
- Flush: flush=1 and wr_enable=1 together at write_ptr=7 -> no write, write_ptr=0, overflow=0. full stays 1 until read_ptr_gray=0 has been synchronised and flush=0, then ST_RUN.
- Almost-full: ALMOST_FULL_THRESH=14 with FIFO_WR_ALMOST_FULL_EN defined -> almost_full=1 on the 14th write edge. With the macro undefined -> almost_full stays 0 throughout.
